// File: rtl/fetch.sv
// fetch: MIPS instruction fetch stage with single outstanding imem request and held output register.
// Optional FETCH_ALIGN_EN forces jump_target word alignment.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DROP} state_t;
  state_t state, state_n;
  logic [31:0] pc_q, req_pc, tgt;
  logic accept, redirect, load;
  assign imem_req = (state == ISSUE) && (!valid || !stall);
  assign imem_addr = pc_q;
  assign accept = imem_req && imem_ready;
  assign redirect = jump && valid;
  assign load = (state == WAIT) && imem_rvalid && !redirect;
  assign opcode = instr[31:26];
  assign funct = instr[5:0];
`ifdef FETCH_ALIGN_EN
  assign tgt = {jump_target[31:2], 2'b00};
`ifndef SYNTHESIS
  always @(posedge clk)
    if (rst_n && redirect && |jump_target[1:0])
      $display("fetch: warning: unaligned jump_target %h forced to %h", jump_target, tgt);
`endif
`else
  assign tgt = jump_target;
`endif
  // a response arriving for a squashed fetch is swallowed in DROP or on the redirect edge
  always_comb begin
    state_n = state == IDLE  ? ISSUE :
              state == ISSUE ? (accept ? (redirect ? DROP : WAIT) : ISSUE) :
              state == WAIT  ? (imem_rvalid ? ISSUE : (redirect ? DROP : WAIT)) :
                               ((imem_rvalid && !redirect) ? ISSUE : DROP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      req_pc <= RESET_PC;
      instr  <= 32'h0;
      pc     <= RESET_PC;
      valid  <= 1'b0;
    end else begin
      state <= state_n;
      pc_q  <= redirect ? tgt : accept ? pc_q + 32'd4 : pc_q;
      if (accept) req_pc <= pc_q;
      if (load) begin
        instr <= imem_rdata;
        pc    <= req_pc;
      end
      valid <= load || (valid && stall && !redirect);
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed and randomized checks of fetch against a transaction-level model of program order.
module tb_fetch;
  localparam logic [31:0] RST1 = 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_EN
  localparam bit ALIGN = 1'b1;
  localparam logic [31:0] UNAL_EXP = 32'h40;
`else
  localparam bit ALIGN = 1'b0;
  localparam logic [31:0] UNAL_EXP = 32'h43;
`endif
  logic clk = 0, rst_n = 0, imem_ready = 0, imem_rvalid = 0, stall = 0, jump = 0;
  logic [31:0] imem_rdata = 0, jump_target = 0;
  logic req, valid, u1_req, u1_valid;
  logic [31:0] addr, instr, pc, u1_addr, u1_instr, u1_pc;
  logic [5:0] opcode, funct, u1_opcode, u1_funct;
  int n_chk = 0, n_err = 0;
  bit m_valid, pend, p_live, live;
  logic [31:0] m_pc, exp_next, p_addr;
  int cnt;
  logic [31:0] acc_q[$], acc1_q[$];

  fetch u0 (.clk(clk), .rst_n(rst_n), .imem_req(req), .imem_addr(addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall), .jump(jump),
    .jump_target(jump_target), .valid(valid), .instr(instr), .pc(pc), .opcode(opcode), .funct(funct));
  fetch #(.RESET_PC(RST1)) u1 (.clk(clk), .rst_n(rst_n), .imem_req(u1_req), .imem_addr(u1_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
    .jump(jump), .jump_target(jump_target), .valid(u1_valid), .instr(u1_instr), .pc(u1_pc),
    .opcode(u1_opcode), .funct(u1_funct));

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; pend = 0; p_live = 0; live = 0; exp_next = 32'h0; cnt = 0; m_pc = 32'h0;
  endtask

  task automatic chk_reset();
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_funct", 32'(funct), 32'h0);
    chk("rst_u1_pc", u1_pc, RST1);
    chk("rst_u1_addr", u1_addr, RST1);
    chk("rst_u1_misc", {u1_instr[19:0], u1_opcode, u1_funct}, {31'h0, u1_valid});
  endtask

  // one clock cycle: drive at posedge+1, check at negedge, advance the model for the coming edge
  task automatic cyc(input bit st, input bit jp, input logic [31:0] tg, input bit rdy, input int lat, input bit stray);
    bit rv, acc, redir;
    logic [31:0] te, w;
    rv = pend && cnt == 0;
    stall = st; jump = jp; jump_target = tg; imem_ready = rdy;
    imem_rvalid = rv || stray;
    imem_rdata = rv ? memw(p_addr) : $urandom;
    @(negedge clk);
    w = memw(m_pc);
    chk("valid", 32'(valid), 32'(m_valid));
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("instr", instr, w);
      chk("opcode", 32'(opcode), 32'(w[31:26]));
      chk("funct", 32'(funct), 32'(w[5:0]));
    end
    chk("req", 32'(req), 32'(live && !pend && !(m_valid && st)));
    chk("addr", addr, exp_next);
    chk("resp_while_held", 32'(imem_rvalid && valid), 32'h0);
    acc = req && rdy;
    redir = jp && m_valid;
    te = ALIGN ? {tg[31:2], 2'b00} : tg;
    if (u1_req && rdy) acc1_q.push_back(u1_addr);
    if (redir) m_valid = 0;
    else if (rv && p_live) begin m_valid = 1; m_pc = p_addr; end
    else if (m_valid && !st) m_valid = 0;
    if (rv) pend = 0;
    if (redir) p_live = 0;
    if (acc) begin
      pend = 1; p_addr = exp_next; p_live = !redir; cnt = lat;
      acc_q.push_back(addr);
    end else if (pend && cnt > 0) cnt--;
    exp_next = redir ? te : acc ? exp_next + 32'd4 : exp_next;
    live = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    int na;
    logic [31:0] tg;
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1;
    repeat (5) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h40, 1, 2, 0);
    chk("n_acc", 32'(acc_q.size()), 32'd3);
    chk("acc0", acc_q[0], 32'h0);
    chk("acc1", acc_q[1], 32'h4);
    chk("acc2", acc_q[2], 32'h8);
    chk("wrap_acc0", acc1_q[0], RST1);
    chk("wrap_acc1", acc1_q[1], 32'h0);
    for (int i = 0; i < 20 && !valid; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("wait_valid", 32'(valid), 32'h1);
    chk("pc_after_jump", pc, 32'h40);
    chk("acc_after_jump", acc_q[3], 32'h40);
    na = acc_q.size();
    repeat (5) cyc(1, 0, 0, 1, 0, 0);
    chk("stall_no_acc", 32'(acc_q.size()), 32'(na));
    chk("stall_instr", instr, memw(32'h40));
    cyc(0, 0, 0, 1, 0, 0);
    chk("release_acc", 32'(acc_q.size()), 32'(na + 1));
    for (int i = 0; i < 20 && !valid; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h43, 1, 0, 0);
    for (int i = 0; i < 20 && !valid; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("align_acc", acc_q[acc_q.size() - 1], UNAL_EXP);
    chk("align_pc", pc, UNAL_EXP);
    cyc(0, 1, 32'h100, 1, 0, 0);
    for (int i = 0; i < 20 && !valid; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 3, 0);
    #2 rst_n = 0;
    #1 chk_reset();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    cyc(0, 0, 0, 1, 0, 1);
    chk("stray", 32'(valid), 32'h0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("stray_next", 32'(valid), 32'h0);
    repeat (600) begin
      tg = $urandom_range(0, 9) == 0 ? ($urandom & 32'hFFF) : {20'h0, 10'($urandom), 2'b00};
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, tg,
          $urandom_range(0, 9) < 7, $urandom_range(0, 3), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
